demorgan_sweep_ctrl: RTL and testbench
======================================

Name: demorgan_sweep_ctrl

Overview:
- Sequencer that drives a two-input De Morgan gate datapath (outputs nA, nB, nAandnB, AnandB, nAornB, AnorB) through all four input combinations.
- After a start pulse it applies each (A,B) row, waits a settle interval, samples the six outputs, checks them against expected values, and logs each row.
- Reports per-row pass/fail on done.
- Sits between a test/host controller and the combinational demorgan instance; replaces hand-written stimulus sequences with clocked self-check.

Parameters:
SETTLE_CYCLES, 1, cycles a row is held before sampling; legal range 1..15; 0 is illegal.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  sweep request; honoured only in IDLE.
a_out  output  1  A input driven to the datapath.
b_out  output  1  B input driven to the datapath.
dut_nA, dut_nB, dut_nAandnB, dut_AnandB, dut_nAornB, dut_AnorB  input  1 each  datapath outputs.
busy  output  1  sweep in progress.
done  output  1  one-cycle completion pulse.
pass  output  1  1 = all four rows matched; valid from done until the next accepted start.
fail_mask  output  4  bit i = 1 if row i mismatched.
row_valid  output  1  one-cycle pulse per sampled row.
row_idx  output  2  row index for row_valid.
row_bits  output  6  sampled {nA,nB,nAandnB,AnandB,nAornB,AnorB}, bit5..bit0.

Behaviour:
- Reset (async, immediate, any state including mid-sweep): all outputs are 0 and state = IDLE. This covers a_out, b_out, busy, done, pass, fail_mask, row_valid, row_idx, row_bits; idx = 0 and settle_cnt = 0.
- Row i mapping: a_out = i[1], b_out = i[0]. Rows run 0,1,2,3 (AB = 00, 01, 10, 11).
- Expected values:
  - nA = ~A, nB = ~B.
  - nAandnB = ~A & ~B; AnorB = ~(A | B).
  - AnandB = ~(A & B); nAornB = ~A | ~B.
  - Expected row_bits: row0 111111, row1 100110, row2 010110, row3 000000.
- FSM, registered state:
  - IDLE: on start=1 at an edge, set idx=0, a_out=0, b_out=0, settle_cnt=0, fail_mask=0, pass=0, busy=1; go to SETTLE.
  - SETTLE: settle_cnt increments each cycle. When settle_cnt == SETTLE_CYCLES-1, go to SAMPLE. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
  - SAMPLE (1 cycle): the dut_* inputs are sampled at the exiting edge.
    - Registered on that edge: row_valid=1, row_idx=idx, row_bits=sampled value, fail_mask[idx] = (sampled != expected).
    - If idx == 3: go to DONE, and pass <= (final fail_mask == 0), where the final mask includes row 3.
    - Otherwise: idx++, a_out/b_out updated to the new row, settle_cnt=0, go to SETTLE.
  - DONE (1 cycle): done=1, busy=0; go to IDLE unconditionally. start is ignored in DONE.
- row_valid and done are single-cycle pulses; row 3's row_valid coincides with done.
- Latency: done is high in the cycle after the 4*(SETTLE_CYCLES+1)th rising edge following the start-accepting edge. With SETTLE_CYCLES=1 that is the 8th edge.
- start while busy: ignored; no restart and no state change.
- a_out/b_out hold the row-3 values (1,1) after the sweep until the next accepted start.
- pass and fail_mask hold until the next accepted start, which clears both on the accepting edge.
- Sampling uses only values present during the SAMPLE cycle. dut_* changes during SETTLE have no effect.

Test Plan:
- Correct combinational model attached, SETTLE_CYCLES=1, pulse start → row_valid pulses at edges 2,4,6,8 with row_bits 111111, 100110, 010110, 000000; done at edge 8; pass=1; fail_mask=0000.
- Model with dut_AnorB stuck-at-1 → fail_mask=1110, pass=0. Same model with stuck-at-0 → fail_mask=0001, pass=0.
- start held high for the entire sweep → exactly one sweep, one done pulse. A second sweep begins only after IDLE is re-entered with start=1.
- Assert reset during row 2 SETTLE → all outputs 0 immediately, without waiting for a clock edge. A new start afterwards completes a clean sweep with pass=1.
- SETTLE_CYCLES=3, with dut_nA glitched to the wrong value only during the first two SETTLE cycles of each row → pass=1, done at edge 16 after the start edge.
- Failing sweep followed by a passing sweep → fail_mask/pass cleared on the second accepting edge; final pass=1, fail_mask=0000.

Source files
------------

// File: rtl/demorgan_sweep_ctrl.sv
// Clocked sequencer that walks a two-input De Morgan datapath through all four
// (A,B) rows, samples its six outputs after a settle interval and grades each row.
module demorgan_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1  // legal range 1..15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       a_out,
    output logic       b_out,
    input  logic       dut_nA,
    input  logic       dut_nB,
    input  logic       dut_nAandnB,
    input  logic       dut_AnandB,
    input  logic       dut_nAornB,
    input  logic       dut_AnorB,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic       row_valid,
    output logic [1:0] row_idx,
    output logic [5:0] row_bits
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     r_state;
    logic [1:0] r_idx;
    logic [3:0] r_settle_cnt;
    logic       r_a;
    logic       r_b;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [3:0] r_fail_mask;
    logic       r_row_valid;
    logic [1:0] r_row_idx;
    logic [5:0] r_row_bits;

    logic [5:0] w_sample;
    logic [5:0] w_expected;
    logic [1:0] w_idx_next;
    logic [3:0] w_fail_next;

    // Golden response of a correct De Morgan datapath for one (A,B) row.
    function automatic logic [5:0] expected_row(input logic [1:0] row);
        logic a;
        logic b;
        a = row[1];
        b = row[0];
        return {~a, ~b, ~a & ~b, ~(a & b), ~a | ~b, ~(a | b)};
    endfunction

    assign w_sample   = {dut_nA, dut_nB, dut_nAandnB, dut_AnandB, dut_nAornB, dut_AnorB};
    assign w_expected = expected_row(r_idx);
    assign w_idx_next = r_idx + 2'd1;

    always_comb begin
        w_fail_next        = r_fail_mask;
        w_fail_next[r_idx] = (w_sample != w_expected);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_idx        <= 2'd0;
            r_settle_cnt <= 4'd0;
            r_a          <= 1'b0;
            r_b          <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail_mask  <= 4'd0;
            r_row_valid  <= 1'b0;
            r_row_idx    <= 2'd0;
            r_row_bits   <= 6'd0;
        end else begin
            r_row_valid <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx        <= 2'd0;
                        r_a          <= 1'b0;
                        r_b          <= 1'b0;
                        r_settle_cnt <= 4'd0;
                        r_fail_mask  <= 4'd0;
                        r_pass       <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    r_settle_cnt <= r_settle_cnt + 4'd1;
                    if (r_settle_cnt == SETTLE_LAST) begin
                        r_state <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    // Datapath outputs are only trusted on the edge leaving this state.
                    r_row_valid <= 1'b1;
                    r_row_idx   <= r_idx;
                    r_row_bits  <= w_sample;
                    r_fail_mask <= w_fail_next;
                    if (r_idx == 2'd3) begin
                        r_pass  <= (w_fail_next == 4'd0);
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_idx        <= w_idx_next;
                        r_a          <= w_idx_next[1];
                        r_b          <= w_idx_next[0];
                        r_settle_cnt <= 4'd0;
                        r_state      <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign a_out     = r_a;
    assign b_out     = r_b;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail_mask = r_fail_mask;
    assign row_valid = r_row_valid;
    assign row_idx   = r_row_idx;
    assign row_bits  = r_row_bits;

endmodule

// File: tb/tb_demorgan_sweep_ctrl.sv
// Bench for demorgan_sweep_ctrl: two instances (settle 1 and 3) driven by a
// behavioural datapath with injectable faults, graded against a row/timing model.
module tb_demorgan_sweep_ctrl;

    logic       clk;
    logic       rst       [2];
    logic       start     [2];
    logic       a_out     [2];
    logic       b_out     [2];
    logic       busy      [2];
    logic       done      [2];
    logic       pass      [2];
    logic [3:0] fail_mask [2];
    logic       row_valid [2];
    logic [1:0] row_idx   [2];
    logic [5:0] row_bits  [2];
    logic [5:0] dbits     [2];

    logic [5:0] s1    [2];
    logic [5:0] s0    [2];
    logic [5:0] noise [2];
    logic [5:0] flip  [2][4];

    int vectors = 0;
    int miscompares = 0;

    // Correct datapath response for row (A = row/2, B = row%2), from the truth rules.
    function automatic logic [5:0] good(input int row);
        int a;
        int b;
        logic [5:0] g;
        a = row / 2;
        b = row % 2;
        g[5] = (a == 0);
        g[4] = (b == 0);
        g[3] = (a + b == 0);
        g[2] = (a * b == 0);
        g[1] = (a * b == 0);
        g[0] = (a + b == 0);
        return g;
    endfunction

    function automatic int settle_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Faulty datapath seen by the sequencer on the current row.
    function automatic logic [5:0] faulty(input int k, input int row);
        return ((good(row) ^ flip[k][row]) | s1[k]) & ~s0[k];
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dp
        assign dbits[g] = (((good(int'({a_out[g], b_out[g]})) ^ flip[g][{a_out[g], b_out[g]}]
                           ^ noise[g]) | s1[g]) & ~s0[g]);
    end

    demorgan_sweep_ctrl #(.SETTLE_CYCLES(1)) u_dut_s1 (
        .clk(clk), .reset(rst[0]), .start(start[0]),
        .a_out(a_out[0]), .b_out(b_out[0]),
        .dut_nA(dbits[0][5]), .dut_nB(dbits[0][4]), .dut_nAandnB(dbits[0][3]),
        .dut_AnandB(dbits[0][2]), .dut_nAornB(dbits[0][1]), .dut_AnorB(dbits[0][0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .fail_mask(fail_mask[0]),
        .row_valid(row_valid[0]), .row_idx(row_idx[0]), .row_bits(row_bits[0])
    );

    demorgan_sweep_ctrl #(.SETTLE_CYCLES(3)) u_dut_s3 (
        .clk(clk), .reset(rst[1]), .start(start[1]),
        .a_out(a_out[1]), .b_out(b_out[1]),
        .dut_nA(dbits[1][5]), .dut_nB(dbits[1][4]), .dut_nAandnB(dbits[1][3]),
        .dut_AnandB(dbits[1][2]), .dut_nAornB(dbits[1][1]), .dut_AnorB(dbits[1][0]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .fail_mask(fail_mask[1]),
        .row_valid(row_valid[1]), .row_idx(row_idx[1]), .row_bits(row_bits[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input int k, input string tag);
        chk({tag, " a_out"}, 32'(a_out[k]), 0);
        chk({tag, " b_out"}, 32'(b_out[k]), 0);
        chk({tag, " busy"}, 32'(busy[k]), 0);
        chk({tag, " done"}, 32'(done[k]), 0);
        chk({tag, " pass"}, 32'(pass[k]), 0);
        chk({tag, " fail_mask"}, 32'(fail_mask[k]), 0);
        chk({tag, " row_valid"}, 32'(row_valid[k]), 0);
        chk({tag, " row_idx"}, 32'(row_idx[k]), 0);
        chk({tag, " row_bits"}, 32'(row_bits[k]), 0);
    endtask

    task automatic clear_faults(input int k);
        s1[k] = 6'd0;
        s0[k] = 6'd0;
        noise[k] = 6'd0;
        for (int r = 0; r < 4; r++) flip[k][r] = 6'd0;
    endtask

    // One full sweep: start accepted at edge 0, then every edge up to N+1 is graded.
    task automatic run_sweep(input int k, input bit keep, input bit glitch);
        int S;
        int N;
        int row;
        int ph;
        logic [3:0] emask;
        logic [5:0] erow [4];
        S = settle_of(k);
        N = 4 * (S + 1);
        for (int r = 0; r < 4; r++) begin
            erow[r] = faulty(k, r);
            emask[r] = (erow[r] != good(r));
        end
        @(negedge clk);
        start[k] = 1'b1;
        noise[k] = 6'd0;
        @(posedge clk);
        #1;
        if (!keep) start[k] = 1'b0;
        chk("accept busy", 32'(busy[k]), 1);
        chk("accept pass cleared", 32'(pass[k]), 0);
        chk("accept fail_mask cleared", 32'(fail_mask[k]), 0);
        chk("accept ab", 32'({a_out[k], b_out[k]}), 0);
        noise[k] = glitch ? 6'h20 : 6'($urandom);
        for (int e = 1; e <= N; e++) begin
            @(posedge clk);
            #1;
            row = (e / (S + 1) > 3) ? 3 : e / (S + 1);
            ph = e % (S + 1);
            chk("row_valid", 32'(row_valid[k]), 32'(ph == 0));
            chk("done", 32'(done[k]), 32'(e == N));
            chk("busy", 32'(busy[k]), 32'(e != N));
            chk("ab", 32'({a_out[k], b_out[k]}), 32'(row));
            if (ph == 0) begin
                chk("row_idx", 32'(row_idx[k]), 32'(e / (S + 1) - 1));
                chk("row_bits", 32'(row_bits[k]), 32'(erow[e / (S + 1) - 1]));
            end
            if (e == N) begin
                chk("fail_mask", 32'(fail_mask[k]), 32'(emask));
                chk("pass", 32'(pass[k]), 32'(emask == 4'd0));
                noise[k] = 6'd0;
            end else if (ph < S) begin
                noise[k] = glitch ? ((ph < 2) ? 6'h20 : 6'd0) : 6'($urandom);
            end else begin
                noise[k] = 6'd0;
            end
            if (!keep) start[k] = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1;
        chk("post busy", 32'(busy[k]), 0);
        chk("post done", 32'(done[k]), 0);
        chk("post row_valid", 32'(row_valid[k]), 0);
        chk("post pass hold", 32'(pass[k]), 32'(emask == 4'd0));
        chk("post fail_mask hold", 32'(fail_mask[k]), 32'(emask));
        chk("post ab hold", 32'({a_out[k], b_out[k]}), 3);
        if (!keep) start[k] = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b0;
            start[k] = 1'b0;
            clear_faults(k);
        end
        #1;
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        #1;
        chk_zero(0, "reset s1");
        chk_zero(1, "reset s3");
        repeat (2) @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        repeat (2) @(negedge clk);

        // Clean sweep with random activity during settle.
        run_sweep(0, 1'b0, 1'b0);

        // AnorB stuck high, then stuck low, then a clean sweep to see the results clear.
        s1[0] = 6'h01;
        run_sweep(0, 1'b0, 1'b0);
        s1[0] = 6'h00;
        s0[0] = 6'h01;
        run_sweep(0, 1'b0, 1'b0);
        s0[0] = 6'h00;
        run_sweep(0, 1'b0, 1'b0);

        // start held high: one sweep, DONE ignores start, next IDLE edge accepts again.
        run_sweep(0, 1'b1, 1'b0);
        run_sweep(0, 1'b0, 1'b0);

        // Asynchronous reset during row 2 settle, with a failed row 0 already logged.
        flip[0][0] = 6'h10;
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        chk("pre-reset ab", 32'({a_out[0], b_out[0]}), 2);
        chk("pre-reset fail_mask", 32'(fail_mask[0]), 1);
        rst[0] = 1'b1;
        #1;
        chk_zero(0, "mid-sweep reset");
        @(negedge clk);
        rst[0] = 1'b0;
        clear_faults(0);
        @(posedge clk);
        #1;
        chk("after reset idle busy", 32'(busy[0]), 0);
        run_sweep(0, 1'b0, 1'b0);

        // Settle of 3 with nA glitched in the first two settle cycles of each row.
        run_sweep(1, 1'b0, 1'b1);
        run_sweep(1, 1'b0, 1'b0);

        // Random faults on random instances.
        for (int n = 0; n < 12; n++) begin
            int k;
            k = int'($urandom_range(0, 1));
            clear_faults(k);
            for (int r = 0; r < 4; r++)
                flip[k][r] = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
            if ($urandom_range(0, 4) == 0) s1[k] = 6'(1 << $urandom_range(0, 5));
            run_sweep(k, 1'b0, 1'b0);
        end
        clear_faults(0);
        run_sweep(0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
